// File: rtl/pool_window_gen_pkg.sv
// Shared CNN definitions for the pooling window path: default pixel width,
// window index type and the window-completion predicate.
package pool_window_gen_pkg;

    localparam int unsigned CNN_DW = 32;

    typedef logic [15:0] win_idx_t;

    // A 2x2 window completes on the pixel at an odd row and odd column.
    function automatic logic is_bottom_right(input logic row_odd, input logic col_odd);
        return row_odd & col_odd;
    endfunction

endpackage

// File: rtl/pool_window_gen_if.sv
// Pixel stream in / 2x2 window out bundle for the pooling window generator.
interface pool_window_gen_if
    import pool_window_gen_pkg::*;
#(
    parameter int unsigned DW = CNN_DW
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] v1;
    logic [DW-1:0] v2;
    logic [DW-1:0] v3;
    logic [DW-1:0] v4;
    logic          out_valid;
    logic          out_ready;
    logic          frame_done;

    modport master (
        input  in_data, in_valid, out_ready,
        output in_ready, v1, v2, v3, v4, out_valid, frame_done
    );

    modport slave (
        output in_data, in_valid, out_ready,
        input  in_ready, v1, v2, v3, v4, out_valid, frame_done
    );
endinterface

// File: rtl/pool_window_gen_line_buf.sv
// Single-row line buffer: one synchronous write port, one combinational read port.
module line_buf #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/pool_window_gen.sv
// Pool window generator: turns a raster pixel stream into non-overlapping 2x2
// windows (v1 v2 / v3 v4) with valid/ready handoff and an end-of-frame pulse.
module pool_window_gen
    import pool_window_gen_pkg::*;
#(
    parameter int unsigned DW    = CNN_DW,
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8
) (
    input logic               clk,
    input logic               reset,
    pool_window_gen_if.master bus
);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [DW-1:0] r_left;
    logic [DW-1:0] r_top_left;
    logic [DW-1:0] r_v1, r_v2, r_v3, r_v4;
    logic          r_out_valid;
    logic          r_frame_done;

    logic          w_accept;
    logic          w_col_last;
    logic          w_row_last;
    logic          w_lb_we;
    logic          w_load;
    logic [DW-1:0] w_lb_rdata;

    assign bus.in_ready = ~(r_out_valid & ~bus.out_ready);
    assign w_accept     = bus.in_valid & bus.in_ready;
    assign w_col_last   = (r_col == COL_LAST);
    assign w_row_last   = (r_row == ROW_LAST);
    assign w_lb_we      = w_accept & ~r_row[0];
    assign w_load       = w_accept & is_bottom_right(r_row[0], r_col[0]);

    line_buf #(
        .DW    (DW),
        .DEPTH (IMG_W),
        .AW    (CW)
    ) u_line_buf (
        .clk     (clk),
        .i_we    (w_lb_we),
        .i_waddr (r_col),
        .i_wdata (bus.in_data),
        .i_raddr (r_col),
        .o_rdata (w_lb_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Single read port: linebuf[c-1] is captured at the even column of the odd
    // row, alongside the left pixel; that row entry is not rewritten before use.
    always_ff @(posedge clk) begin
        if (w_accept && r_row[0] && !r_col[0]) begin
            r_left     <= bus.in_data;
            r_top_left <= w_lb_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1         <= '0;
            r_v2         <= '0;
            r_v3         <= '0;
            r_v4         <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept & w_col_last & w_row_last;
            if (w_load) begin
                r_v1        <= r_top_left;
                r_v2        <= w_lb_rdata;
                r_v3        <= r_left;
                r_v4        <= bus.in_data;
                r_out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.v1         = r_v1;
    assign bus.v2         = r_v2;
    assign bus.v3         = r_v3;
    assign bus.v4         = r_v4;
    assign bus.out_valid  = r_out_valid;
    assign bus.frame_done = r_frame_done;
endmodule

// File: doc/pool_window_gen.md
POOL_WINDOW_GEN -- requirements
Module: pool_window_gen

Interface
REQ-001: Parameter DW, default 32, pixel data width in bits.
REQ-002: Parameter IMG_W, default 8, image width in pixels; must be even and at least 2.
REQ-003: Parameter IMG_H, default 8, image height in pixels; must be even and at least 2.
REQ-004: clk  input  1  single clock; all state updates on posedge clk.
REQ-005: reset  input  1  synchronous, active-high reset.
REQ-006: in_data  input  DW  pixel, raster order (row-major, column 0 first).
REQ-007: in_valid  input  1  in_data is valid this cycle.
REQ-008: in_ready  output  1  block accepts in_data this cycle.
REQ-009: v1  output  DW  window top-left pixel.
REQ-010: v2  output  DW  window top-right pixel.
REQ-011: v3  output  DW  window bottom-left pixel.
REQ-012: v4  output  DW  window bottom-right pixel.
REQ-013: out_valid  output  1  v1..v4 hold a complete window; drives the 2x2 pooler's en.
REQ-014: out_ready  input  1  consumer takes the window this cycle.
REQ-015: frame_done  output  1  one-cycle pulse, coincident with the first out_valid cycle of the frame's last window.

Function
REQ-016: A pixel SHALL be accepted exactly on a cycle where in_valid and in_ready are both 1.
REQ-017: in_ready SHALL equal NOT(out_valid AND NOT out_ready), a combinational function of registered out_valid and input out_ready.
REQ-018: The block SHALL keep a column counter (0..IMG_W-1) and a row counter (0..IMG_H-1), each advancing only on acceptance.
REQ-019: The column counter SHALL wrap to 0 after IMG_W-1 and increment the row counter. The row counter SHALL wrap to 0 after IMG_H-1, so back-to-back frames need no idle cycle.
REQ-020: On even rows, each accepted pixel SHALL be written to a line buffer of IMG_W x DW entries at the column index.
REQ-021: On odd rows, a pixel accepted at an even column SHALL be held in a DW-bit "left" register.
REQ-022: A pixel accepted at an odd row and odd column c SHALL load, on the next edge: v1 = linebuf[c-1], v2 = linebuf[c], v3 = left register, v4 = in_data, and out_valid = 1. Latency is one cycle from acceptance to out_valid.
REQ-023: out_valid SHALL stay 1 with v1..v4 stable until a cycle where out_ready = 1. It then clears on the next edge, unless a new window loads on that same edge, in which case it stays 1 with the new data.
REQ-024: Simultaneous window hand-off and new bottom-right pixel acceptance SHALL be supported with no bubble.
REQ-025: frame_done SHALL be 1 on the single cycle after accepting pixel (IMG_H-1, IMG_W-1), and 0 otherwise.
REQ-026: Exactly (IMG_W/2)*(IMG_H/2) windows SHALL be produced per frame, in raster order of window position.
REQ-027: Line-buffer reads for row r+1 SHALL return the data written during row r. No read-before-write hazard is permitted for IMG_W = 2.
REQ-028: in_data SHALL be ignored when not accepted.

Reset
REQ-029: While reset = 1 at a clock edge, the block SHALL clear the column and row counters, out_valid and frame_done to 0, and clear v1..v4 to 0.
REQ-030: The line buffer and left register SHALL NOT require reset; their contents are don't-care after reset.
REQ-031: A reset mid-frame SHALL discard the partial frame. The first pixel accepted after reset is position (0,0).
REQ-032: During reset, in_ready SHALL be 1 as a consequence of out_valid = 0. Input offered during a reset cycle SHALL NOT be counted.

Structure
REQ-033: The shared CNN package SHALL define the DW default and the window index type. Counter widths SHALL be computed as clog2(IMG_W) and clog2(IMG_H) inside the module.
REQ-034: The line buffer SHALL be one sub-module, line_buf (1 write port, 1 read port, combinational read, IMG_W x DW). All other logic stays in pool_window_gen.

Verification
REQ-035: 4x4 frame, pixels 1..16, in_valid continuous, out_ready = 1 -> windows (1,2,5,6), (3,4,7,8), (9,10,13,14), (11,12,15,16). Each window appears one cycle after pixels 6, 8, 14 and 16 respectively. frame_done coincides with (11,12,15,16).
REQ-036: Same frame with out_ready = 0 from window 1 for 5 cycles -> in_ready = 0 while window 1 is pending and a bottom-right pixel would be blocked. No pixel is lost, and the window sequence is unchanged.
REQ-037: Two back-to-back 4x4 frames (1..16, then 101..116) -> 8 windows. The fifth window is (101,102,105,106), with no idle cycle between frames.
REQ-038: Reset asserted after pixel 7 of a 4x4 frame, then pixels 1..16 are sent -> exactly the 4 windows of REQ-035. out_valid = 0 during reset.
REQ-039: IMG_W = 2, IMG_H = 2, pixels 0xA, 0xB, 0xC, 0xD with random in_valid gaps -> single window (A,B,C,D) with frame_done = 1.
REQ-040: Window path connected to the 2x2 pooler (out_valid to en) with signed random data -> the pooler output matches the reference model max-with-ReLU of each window.
